// File: rtl/csr_rmw.sv
`default_nettype none
// ============================================================================
// Module   : csr_rmw
// Brief    : Zicsr read-modify-write sequencer feeding the CSR storage block.
//            Optional read-only/reserved-op blocking via CSR_RO_CHECK_EN.
// Revision : 1.0
// ============================================================================
module csr_rmw #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [4:0]      req_rs1,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_rs1_data,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal,
    output logic            csr_s_csr,
    output logic            csr_s_csrsc,
    output logic [4:0]      csr_rs1,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_data_w,
    input  logic [XLEN-1:0] csr_data_r
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_op;
    logic [4:0]      r_rs1;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_operand;
    logic [XLEN-1:0] r_old;
    logic            w_accept;
    logic            w_illegal;
    logic            w_strobe;
    logic [XLEN-1:0] w_new;
    logic [XLEN-1:0] w_operand;

    assign w_accept  = req_valid && (r_state == S_IDLE);
    // Immediate forms carry a zero-extended uimm in the rs1 field.
    assign w_operand = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1} : req_rs1_data;

    always_comb begin
        w_new = csr_data_r;
        case (r_op)
            2'b01:   w_new = r_operand;
            2'b10:   w_new = csr_data_r | r_operand;
            2'b11:   w_new = csr_data_r & ~r_operand;
            default: w_new = csr_data_r;
        endcase
    end

`ifdef CSR_RO_CHECK_EN
    logic r_illegal;

    // Read-only space is only an error when the CSR block would actually write.
    assign w_illegal = (r_op == 2'b00) ||
                       ((r_addr[11:10] == 2'b11) &&
                        ((r_op == 2'b01) || (r_op[1] && (r_rs1 != 5'd0))));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (r_state == S_WRITE) begin
            r_illegal <= w_illegal;
        end
    end

    assign resp_illegal = (r_state == S_RESP) && r_illegal;
`else
    assign w_illegal    = 1'b0;
    assign resp_illegal = 1'b0;
`endif

    assign w_strobe = (r_state == S_WRITE) && (r_op != 2'b00) && !w_illegal;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 2'b00;
            r_rs1     <= 5'd0;
            r_addr    <= 12'd0;
            r_operand <= '0;
            r_old     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op      <= req_funct3[1:0];
                r_rs1     <= req_rs1;
                r_addr    <= req_addr;
                r_operand <= w_operand;
            end
            if (r_state == S_WRITE) begin
                r_old <= csr_data_r;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        csr_s_csr   = 1'b0;
        csr_s_csrsc = 1'b0;
        csr_data_w  = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = S_READ;
            end
            S_READ: begin
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                csr_s_csr   = w_strobe;
                csr_s_csrsc = r_op[1];
                csr_data_w  = w_new;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign csr_rs1    = r_rs1;
    assign csr_addr   = r_addr;
    assign resp_rdata = r_old;

endmodule
`default_nettype wire

// File: tb/tb_csr_rmw.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_rmw
// Brief    : Directed self-checking bench for csr_rmw with a CSR RAM model.
// Revision : 1.0
// ============================================================================
module tb_csr_rmw;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rs1;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic        csr_s_csr;
    logic        csr_s_csrsc;
    logic [4:0]  csr_rs1;
    logic [11:0] csr_addr;
    logic [31:0] csr_data_w;
    logic [31:0] csr_data_r;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:4095];
    logic        mem_clr;
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    int          ob_strobes;
    int          ob_strobe_cyc;
    int          ob_resp_cyc;
    logic        ob_ready_bad;
    logic        ob_unstable;
    logic [31:0] ob_data_w;
    logic        ob_csrsc;
    logic [4:0]  ob_rs1;
    logic [31:0] ob_rdata;
    logic        ob_illegal;

    always #5 clock = ~clock;

    csr_rmw #(.XLEN(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_rs1      (req_rs1),
        .req_addr     (req_addr),
        .req_rs1_data (req_rs1_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_illegal (resp_illegal),
        .csr_s_csr    (csr_s_csr),
        .csr_s_csrsc  (csr_s_csrsc),
        .csr_rs1      (csr_rs1),
        .csr_addr     (csr_addr),
        .csr_data_w   (csr_data_w),
        .csr_data_r   (csr_data_r)
    );

    // CSR storage: synchronous read, write suppressed for set/clear with rs1=0.
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (csr_s_csr && !(csr_s_csrsc && csr_rs1 == 5'd0)) begin
            mem[csr_addr] <= csr_data_w;
        end
        csr_data_r <= mem[csr_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [4:0] rs1,
                          input logic [11:0] addr, input logic [31:0] data, input int hold);
        int cyc;
        ob_strobes = 0; ob_strobe_cyc = -1; ob_resp_cyc = -1;
        ob_ready_bad = 1'b0; ob_unstable = 1'b0;
        ob_data_w = 32'h0; ob_csrsc = 1'b0; ob_rs1 = 5'd0;
        ob_rdata = 32'h0; ob_illegal = 1'b0;
        req_valid = 1'b1; req_funct3 = f3; req_rs1 = rs1; req_addr = addr;
        req_rs1_data = data; resp_ready = 1'b0;
        @(negedge clock);
        req_valid = 1'b0; req_rs1_data = 32'h5A5A5A5A; req_rs1 = 5'h0A;
        req_addr = 12'hFFF; req_funct3 = 3'b011;
        cyc = 1;
        while (ob_resp_cyc < 0 && cyc < 12) begin
            if (req_ready) ob_ready_bad = 1'b1;
            if (csr_s_csr) begin
                ob_strobes++; ob_strobe_cyc = cyc;
                ob_data_w = csr_data_w; ob_csrsc = csr_s_csrsc; ob_rs1 = csr_rs1;
            end
            if (resp_valid) begin
                ob_resp_cyc = cyc; ob_rdata = resp_rdata; ob_illegal = resp_illegal;
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (csr_s_csr) ob_strobes++;
            if (req_ready) ob_ready_bad = 1'b1;
            if (!resp_valid || resp_rdata !== ob_rdata || resp_illegal !== ob_illegal)
                ob_unstable = 1'b1;
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; mem_clr = 1'b1; pl_en = 1'b0; pl_addr = 12'h0; pl_data = 32'h0;
        req_valid = 1'b0; req_funct3 = 3'b000; req_rs1 = 5'd0; req_addr = 12'h0;
        req_rs1_data = 32'h0; resp_ready = 1'b0;
        repeat (2) @(negedge clock);
        mem_clr = 1'b0;

        chk("rst_req_ready",   32'(req_ready),    32'h1);
        chk("rst_resp_valid",  32'(resp_valid),   32'h0);
        chk("rst_resp_rdata",  resp_rdata,        32'h0);
        chk("rst_resp_illegal",32'(resp_illegal), 32'h0);
        chk("rst_s_csr",       32'(csr_s_csr),    32'h0);
        chk("rst_csrsc",       32'(csr_s_csrsc),  32'h0);
        chk("rst_csr_rs1",     32'(csr_rs1),      32'h0);
        chk("rst_csr_addr",    32'(csr_addr),     32'h0);
        chk("rst_data_w",      csr_data_w,        32'h0);
        reset = 1'b0;
        preload(12'h305, 32'h80000000);
        preload(12'hC00, 32'h12345678);

        // CSRRW 0x340 <- DEADBEEF over 0
        run_op(3'b001, 5'd3, 12'h340, 32'hDEADBEEF, 0);
        chk("rw_strobes",   32'(ob_strobes),    32'd1);
        chk("rw_strobe_cyc",32'(ob_strobe_cyc), 32'd2);
        chk("rw_data_w",    ob_data_w,          32'hDEADBEEF);
        chk("rw_resp_cyc",  32'(ob_resp_cyc),   32'd3);
        chk("rw_rdata",     ob_rdata,           32'h0);
        chk("rw_illegal",   32'(ob_illegal),    32'h0);
        chk("rw_ready_low", 32'(ob_ready_bad),  32'h0);
        chk("rw_idle_ready",32'(req_ready),     32'h1);
        chk("rw_mem",       mem[12'h340],       32'hDEADBEEF);

        // Re-read via CSRRS x0
        run_op(3'b010, 5'd0, 12'h340, 32'h0, 0);
        chk("reread_rdata", ob_rdata,           32'hDEADBEEF);
        chk("reread_csrsc", 32'(ob_csrsc),      32'h1);
        chk("reread_mem",   mem[12'h340],       32'hDEADBEEF);

        // Set then clear
        preload(12'h340, 32'h0F0F0000);
        run_op(3'b010, 5'd5, 12'h340, 32'h000000F0, 0);
        chk("rs_data_w",    ob_data_w,          32'h0F0F00F0);
        chk("rs_rdata",     ob_rdata,           32'h0F0F0000);
        chk("rs_csrsc",     32'(ob_csrsc),      32'h1);
        chk("rs_rs1",       32'(ob_rs1),        32'd5);
        run_op(3'b011, 5'd6, 12'h340, 32'h0F000000, 0);
        chk("rc_data_w",    ob_data_w,          32'h000F00F0);
        chk("rc_rdata",     ob_rdata,           32'h0F0F00F0);
        chk("rc_mem",       mem[12'h340],       32'h000F00F0);

        // Immediate forms on 0x305
        run_op(3'b110, 5'd0, 12'h305, 32'hFFFFFFFF, 0);
        chk("rsi0_strobes", 32'(ob_strobes),    32'd1);
        chk("rsi0_csrsc",   32'(ob_csrsc),      32'h1);
        chk("rsi0_rs1",     32'(ob_rs1),        32'h0);
        chk("rsi0_data_w",  ob_data_w,          32'h80000000);
        chk("rsi0_rdata",   ob_rdata,           32'h80000000);
        chk("rsi0_mem",     mem[12'h305],       32'h80000000);
        run_op(3'b101, 5'h1F, 12'h305, 32'hFFFFFFFF, 0);
        chk("rwi_data_w",   ob_data_w,          32'h0000001F);
        chk("rwi_csrsc",    32'(ob_csrsc),      32'h0);
        chk("rwi_rdata",    ob_rdata,           32'h80000000);
        run_op(3'b111, 5'h11, 12'h305, 32'h0, 0);
        chk("rci_data_w",   ob_data_w,          32'h0000000E);
        chk("rci_rs1",      32'(ob_rs1),        32'h11);
        chk("rci_rdata",    ob_rdata,           32'h0000001F);

        // Backpressure: resp_ready low for 5 cycles
        run_op(3'b010, 5'd0, 12'h340, 32'h0, 5);
        chk("hold_unstable",32'(ob_unstable),   32'h0);
        chk("hold_ready",   32'(ob_ready_bad),  32'h0);
        chk("hold_strobes", 32'(ob_strobes),    32'd1);
        chk("hold_rdata",   ob_rdata,           32'h000F00F0);

        // Reset during READ
        req_valid = 1'b1; req_funct3 = 3'b001; req_rs1 = 5'd1; req_addr = 12'h340;
        req_rs1_data = 32'hAAAAAAAA;
        @(negedge clock);
        req_valid = 1'b0;
        chk("mid_read_ready", 32'(req_ready),   32'h0);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_ready",  32'(req_ready),   32'h1);
        chk("mid_rst_valid",  32'(resp_valid),  32'h0);
        chk("mid_rst_strobe", 32'(csr_s_csr),   32'h0);
        chk("mid_rst_addr",   32'(csr_addr),    32'h0);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (csr_s_csr || resp_valid) n++;
        end
        chk("mid_rst_quiet",  32'(n),           32'd0);
        chk("mid_rst_mem",    mem[12'h340],     32'h000F00F0);

        // Read-only space
        run_op(3'b001, 5'd2, 12'hC00, 32'h00000055, 0);
`ifdef CSR_RO_CHECK_EN
        chk("ro_rw_strobes",  32'(ob_strobes),  32'd0);
        chk("ro_rw_illegal",  32'(ob_illegal),  32'h1);
        chk("ro_rw_rdata",    ob_rdata,         32'h12345678);
        run_op(3'b010, 5'd0, 12'hC00, 32'h0, 0);
        chk("ro_rs0_illegal", 32'(ob_illegal),  32'h0);
        chk("ro_rs0_rdata",   ob_rdata,         32'h12345678);
`else
        chk("ro_rw_strobes",  32'(ob_strobes),  32'd1);
        chk("ro_rw_illegal",  32'(ob_illegal),  32'h0);
        chk("ro_rw_rdata",    ob_rdata,         32'h12345678);
        run_op(3'b010, 5'd0, 12'hC00, 32'h0, 0);
        chk("ro_rs0_illegal", 32'(ob_illegal),  32'h0);
        chk("ro_rs0_rdata",   ob_rdata,         32'h00000055);
`endif

        // Reserved funct3
        run_op(3'b000, 5'd7, 12'h340, 32'hFFFFFFFF, 0);
        chk("rsv_strobes",    32'(ob_strobes),  32'd0);
        chk("rsv_resp_cyc",   32'(ob_resp_cyc), 32'd3);
        chk("rsv_rdata",      ob_rdata,         32'h000F00F0);
`ifdef CSR_RO_CHECK_EN
        chk("rsv_illegal",    32'(ob_illegal),  32'h1);
`else
        chk("rsv_illegal",    32'(ob_illegal),  32'h0);
`endif
        chk("rsv_mem",        mem[12'h340],     32'h000F00F0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
